// File: rtl/cordic_sincos_arbiter.sv
// Round-robin front end for a shared pipelined CORDIC sin/cos unit: normalizes
// granted angles, tags each issue with its requester and routes results back.
module cordic_sincos_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int LATENCY   = 18,
  parameter int FULL_TURN = 368640
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      ienable,
  input  logic [NREQ-1:0]           ireq_valid,
  input  logic [21*NREQ-1:0]        ireq_angle,
  output logic [NREQ-1:0]           oreq_ready,
  output logic signed [20:0]        ocordic_z,
  input  logic signed [20:0]        icordic_x,
  input  logic signed [20:0]        icordic_y,
  output logic [NREQ-1:0]           ores_valid,
  output logic signed [20:0]        ores_cos,
  output logic signed [20:0]        ores_sin,
  output logic [NREQ-1:0]           oerr_valid,
  output logic [4:0]                oinflight,
  output logic                      obusy
);

  localparam int DATA_W = 21;
  localparam logic signed [DATA_W:0] FT_W  = (DATA_W+1)'(FULL_TURN);
  localparam logic signed [DATA_W:0] FT2_W = (DATA_W+1)'(2*FULL_TURN);

  function automatic logic out_of_range(input logic signed [DATA_W-1:0] a);
    logic signed [DATA_W:0] a_w;
    a_w = {a[DATA_W-1], a};
    return (a_w < -FT_W) || (a_w >= FT2_W);
  endfunction

  // Folds one turn either way; only called on angles already known in range.
  function automatic logic signed [DATA_W-1:0] wrap_angle(input logic signed [DATA_W-1:0] a);
    logic signed [DATA_W:0] a_w;
    a_w = {a[DATA_W-1], a};
    if (a_w < 0)
      return DATA_W'(a_w + FT_W);
    else if (a_w >= FT_W)
      return DATA_W'(a_w - FT_W);
    else
      return a;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    return NREQ'(1) << id;
  endfunction

  logic [IDW-1:0]            r_ptr;
  logic [NREQ-1:0]           w_grant;
  logic [IDW-1:0]            w_gidx;
  logic                      w_found;
  logic signed [DATA_W-1:0]  w_angle;
  logic                      w_oor;
  logic                      w_issue;
  logic                      w_retire;

  logic signed [DATA_W-1:0]  r_z_p0;
  logic [NREQ-1:0]           r_err_p0;
  logic [LATENCY:0]          r_tag_vld;
  logic [IDW-1:0]            r_tag_id [0:LATENCY];
  logic [NREQ-1:0]           r_res_vld;
  logic signed [DATA_W-1:0]  r_cos;
  logic signed [DATA_W-1:0]  r_sin;
  logic [NREQ-1:0]           r_err_vld;
  logic [4:0]                r_inflight;

  always_comb begin
    int idx;
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_angle = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (ienable && !w_found && ireq_valid[idx]) begin
        w_found = 1'b1;
        w_gidx  = IDW'(idx);
        w_grant = onehot(IDW'(idx));
        w_angle = ireq_angle[idx*DATA_W +: DATA_W];
      end
    end
  end

  assign oreq_ready = w_grant;
  assign w_oor      = out_of_range(w_angle);
  assign w_issue    = w_found && !w_oor;
  assign w_retire   = r_tag_vld[LATENCY];

  // Stage p0: arbitration, normalization and issue to the CORDIC
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_ptr      <= IDW'(NREQ-1);
      r_z_p0     <= '0;
      r_err_p0   <= '0;
      r_err_vld  <= '0;
      r_tag_vld  <= '0;
      r_res_vld  <= '0;
      r_cos      <= '0;
      r_sin      <= '0;
      r_inflight <= '0;
    end else begin
      if (w_found)
        r_ptr <= w_gidx;
      if (w_issue)
        r_z_p0 <= wrap_angle(w_angle);
      r_err_p0  <= (w_found && w_oor) ? onehot(w_gidx) : '0;
      r_err_vld <= r_err_p0;
      r_tag_vld <= {r_tag_vld[LATENCY-1:0], w_issue};
      // Retire stage: tag at the end of the pipe matches the live CORDIC outputs
      if (w_retire) begin
        r_res_vld <= onehot(r_tag_id[LATENCY]);
        r_cos     <= icordic_x;
        r_sin     <= icordic_y;
      end else begin
        r_res_vld <= '0;
      end
      case ({w_issue, w_retire})
        2'b10:   r_inflight <= r_inflight + 5'd1;
        2'b01:   r_inflight <= r_inflight - 5'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Requester ids ride alongside the valid bits; stale ids are harmless
  always_ff @(posedge iclk) begin
    r_tag_id[0] <= w_gidx;
    for (int s = 1; s <= LATENCY; s++)
      r_tag_id[s] <= r_tag_id[s-1];
  end

  assign ocordic_z  = r_z_p0;
  assign ores_valid = r_res_vld;
  assign ores_cos   = r_cos;
  assign ores_sin   = r_sin;
  assign oerr_valid = r_err_vld;
  assign oinflight  = r_inflight;
  assign obusy      = (r_inflight != 5'd0);

endmodule

// File: tb/tb_cordic_sincos_arbiter.sv
// Bench for cordic_sincos_arbiter: behavioural CORDIC stand-in plus a
// transaction-level model of arbitration, normalization and result return.
module tb_cordic_sincos_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 18;
  localparam int FT   = 368640;
  localparam int DW   = 21;

  logic                     iclk = 1'b0;
  logic                     ireset = 1'b0;
  logic                     ienable = 1'b0;
  logic [NREQ-1:0]          ireq_valid = '0;
  logic [DW*NREQ-1:0]       ireq_angle = '0;
  logic [NREQ-1:0]          oreq_ready;
  logic signed [DW-1:0]     ocordic_z;
  logic signed [DW-1:0]     icordic_x;
  logic signed [DW-1:0]     icordic_y;
  logic [NREQ-1:0]          ores_valid;
  logic signed [DW-1:0]     ores_cos;
  logic signed [DW-1:0]     ores_sin;
  logic [NREQ-1:0]          oerr_valid;
  logic [4:0]               oinflight;
  logic                     obusy;

  cordic_sincos_arbiter #(.NREQ(NREQ), .IDW(2), .LATENCY(LAT), .FULL_TURN(FT)) dut (
    .iclk(iclk), .ireset(ireset), .ienable(ienable),
    .ireq_valid(ireq_valid), .ireq_angle(ireq_angle), .oreq_ready(oreq_ready),
    .ocordic_z(ocordic_z), .icordic_x(icordic_x), .icordic_y(icordic_y),
    .ores_valid(ores_valid), .ores_cos(ores_cos), .ores_sin(ores_sin),
    .oerr_valid(oerr_valid), .oinflight(oinflight), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  function automatic int cs(input int z, input bit want_sin);
    real ang;
    ang = real'(z) * 3.14159265358979 / (180.0 * 1024.0);
    return want_sin ? int'(65536.0 * $sin(ang)) : int'(65536.0 * $cos(ang));
  endfunction

  // CORDIC stand-in: outputs follow ocordic_z by LAT edges
  int zp [0:LAT-1];
  initial for (int s = 0; s < LAT; s++) zp[s] = 0;
  always @(posedge iclk) begin
    zp[0] <= int'(ocordic_z);
    for (int s = 1; s < LAT; s++) zp[s] <= zp[s-1];
  end
  assign icordic_x = DW'(cs(zp[LAT-1], 1'b0));
  assign icordic_y = DW'(cs(zp[LAT-1], 1'b1));

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int m_ptr = NREQ-1, mz = 0, m_cos = 0, m_sin = 0;
  int exp_res [int];
  int exp_rz  [int];
  int exp_err [int];
  int issues  [$];
  bit mon_en = 1'b0;

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr, input bit en);
    if (!en) return -1;
    for (int k = 1; k <= NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic int norm(input int a);
    if (a < -FT || a >= 2*FT) return -1;
    if (a < 0) return a + FT;
    if (a >= FT) return a - FT;
    return a;
  endfunction

  function automatic int ang_of(input logic [DW*NREQ-1:0] angs, input int r);
    logic signed [DW-1:0] t;
    t = angs[r*DW +: DW];
    return int'(t);
  endfunction

  function automatic logic [DW*NREQ-1:0] rand_angs(input bit allow_oor);
    logic [DW*NREQ-1:0] v;
    int a;
    v = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (allow_oor) a = int'($urandom_range(0, 3*FT + 1)) - FT - 1;
      else           a = int'($urandom_range(0, FT - 1));
      v[r*DW +: DW] = DW'(a);
    end
    return v;
  endfunction

  task automatic drive(input logic [NREQ-1:0] v, input logic [DW*NREQ-1:0] angs,
                       input bit en, input bit rst);
    ireq_valid = v;
    ireq_angle = angs;
    ienable    = en;
    ireset     = rst;
    #1;
  endtask

  // One clock edge; the model commits whatever the DUT is seeing on its inputs
  task automatic tick();
    int g, a, z;
    bit rst;
    rst = ireset;
    g = rst ? -1 : pick(ireq_valid, m_ptr, ienable);
    a = (g >= 0) ? ang_of(ireq_angle, g) : 0;
    @(posedge iclk);
    cyc++;
    if (rst) begin
      m_ptr = NREQ-1; mz = 0; m_cos = 0; m_sin = 0;
      exp_res.delete(); exp_rz.delete(); exp_err.delete(); issues.delete();
    end else if (g >= 0) begin
      m_ptr = g;
      z = norm(a);
      if (z < 0) exp_err[cyc+1] = g;
      else begin
        mz = z;
        exp_res[cyc+LAT+1] = g;
        exp_rz[cyc+LAT+1]  = z;
        issues.push_back(cyc);
      end
    end
    @(negedge iclk);
  endtask

  always @(negedge iclk) begin
    if (mon_en) begin
      logic [NREQ-1:0] ev, ee;
      ev = exp_res.exists(cyc) ? NREQ'(1 << exp_res[cyc]) : '0;
      ee = exp_err.exists(cyc) ? NREQ'(1 << exp_err[cyc]) : '0;
      if (ev != 0) begin
        m_cos = cs(exp_rz[cyc], 1'b0);
        m_sin = cs(exp_rz[cyc], 1'b1);
      end
      while (issues.size() > 0 && cyc - issues[0] > LAT) void'(issues.pop_front());
      n_chk++;
      if (ores_valid !== ev) begin
        n_err++; $display("FAIL res_valid cyc=%0d: got %b expected %b", cyc, ores_valid, ev);
      end
      n_chk++;
      if (ores_cos !== DW'(m_cos) || ores_sin !== DW'(m_sin)) begin
        n_err++; $display("FAIL res_data cyc=%0d: got %0d/%0d expected %0d/%0d", cyc, ores_cos, ores_sin, m_cos, m_sin);
      end
      n_chk++;
      if (oerr_valid !== ee) begin
        n_err++; $display("FAIL err_valid cyc=%0d: got %b expected %b", cyc, oerr_valid, ee);
      end
      n_chk++;
      if (oinflight !== 5'(issues.size()) || obusy !== (issues.size() != 0)) begin
        n_err++; $display("FAIL inflight cyc=%0d: got %0d busy=%b expected %0d", cyc, oinflight, obusy, issues.size());
      end
      n_chk++;
      if (ocordic_z !== DW'(mz)) begin
        n_err++; $display("FAIL cordic_z cyc=%0d: got %0d expected %0d", cyc, ocordic_z, mz);
      end
    end
  end

  task automatic test_reset();
    drive('0, '0, 1'b1, 1'b1);
    tick();
    tick();
    mon_en = 1'b1;
    drive('0, '0, 1'b1, 1'b0);
    n_chk++;
    if (ores_valid !== '0 || oerr_valid !== '0 || ocordic_z !== '0 || oinflight !== '0 || obusy !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got v=%b e=%b z=%0d n=%0d b=%b expected all zero", ores_valid, oerr_valid, ocordic_z, oinflight, obusy);
    end
    n_chk++;
    if (oreq_ready !== '0) begin
      n_err++; $display("FAIL reset_ready: got %b expected 0", oreq_ready);
    end
  endtask

  task automatic test_single();
    logic [DW*NREQ-1:0] angs;
    angs = '0;
    angs[0 +: DW] = DW'(30720);
    drive(4'b0001, angs, 1'b1, 1'b0);
    n_chk++;
    if (oreq_ready !== 4'b0001) begin
      n_err++; $display("FAIL single_grant: got %b expected 0001", oreq_ready);
    end
    tick();
    drive('0, '0, 1'b1, 1'b0);
    n_chk++;
    if (ocordic_z !== 21'sd30720 || oinflight !== 5'd1) begin
      n_err++; $display("FAIL single_issue: got z=%0d n=%0d expected 30720/1", ocordic_z, oinflight);
    end
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 18) begin
        n_chk++;
        if (ores_valid !== '0 || oinflight !== 5'd1) begin
          n_err++; $display("FAIL single_early: got v=%b n=%0d expected 0/1", ores_valid, oinflight);
        end
      end
      if (j == 19) begin
        n_chk++;
        if (ores_valid !== 4'b0001 || oinflight !== 5'd0) begin
          n_err++; $display("FAIL single_retire: got v=%b n=%0d expected 0001/0", ores_valid, oinflight);
        end
        n_chk++;
        if ((ores_cos - 56756 > 64) || (56756 - ores_cos > 64) || (ores_sin - 32768 > 64) || (32768 - ores_sin > 64)) begin
          n_err++; $display("FAIL single_value: got %0d/%0d expected 56756/32768", ores_cos, ores_sin);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int seen [$];
    drive('0, '0, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, rand_angs(1'b0), 1'b1, 1'b0);
      n_chk++;
      if (oreq_ready !== NREQ'(1 << (k % NREQ))) begin
        n_err++; $display("FAIL b2b_grant k=%0d: got %b expected %0d", k, oreq_ready, k % NREQ);
      end
      tick();
    end
    drive('0, '0, 1'b1, 1'b0);
    n_chk++;
    if (oinflight !== 5'd8) begin
      n_err++; $display("FAIL b2b_peak: got %0d expected 8", oinflight);
    end
    for (int j = 0; j < 22; j++) begin
      tick();
      for (int r = 0; r < NREQ; r++) if (ores_valid[r]) seen.push_back(r);
    end
    n_chk++;
    if (seen.size() != 8) begin
      n_err++; $display("FAIL b2b_count: got %0d expected 8", seen.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_chk++;
        if (seen[k] != k % NREQ) begin
          n_err++; $display("FAIL b2b_order k=%0d: got %0d expected %0d", k, seen[k], k % NREQ);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int ins [5] = '{-92160, 460800, 368640, -368640, 368639};
    int exz [5] = '{276480, 92160, 0, 0, 368639};
    logic [DW*NREQ-1:0] angs;
    int r;
    for (int i = 0; i < 5; i++) begin
      r = int'($urandom_range(0, NREQ-1));
      angs = rand_angs(1'b1);
      angs[r*DW +: DW] = DW'(ins[i]);
      drive(NREQ'(1 << r), angs, 1'b1, 1'b0);
      n_chk++;
      if (oreq_ready !== NREQ'(1 << r)) begin
        n_err++; $display("FAIL wrap_grant i=%0d: got %b expected %0d", i, oreq_ready, r);
      end
      tick();
      n_chk++;
      if (ocordic_z !== DW'(exz[i])) begin
        n_err++; $display("FAIL wrap_z i=%0d: got %0d expected %0d", i, ocordic_z, exz[i]);
      end
    end
    drive('0, '0, 1'b1, 1'b0);
    for (int j = 0; j < 21; j++) tick();
  endtask

  task automatic test_out_of_range();
    int vals [2] = '{737280, -368641};
    logic [DW*NREQ-1:0] angs;
    int r;
    for (int i = 0; i < 2; i++) begin
      r = int'($urandom_range(0, NREQ-1));
      angs = '0;
      angs[r*DW +: DW] = DW'(vals[i]);
      drive(NREQ'(1 << r), angs, 1'b1, 1'b0);
      tick();
      drive('0, '0, 1'b1, 1'b0);
      n_chk++;
      if (oinflight !== 5'd0 || oerr_valid !== '0) begin
        n_err++; $display("FAIL oor_accept i=%0d: got n=%0d e=%b expected 0/0", i, oinflight, oerr_valid);
      end
      tick();
      n_chk++;
      if (oerr_valid !== NREQ'(1 << r)) begin
        n_err++; $display("FAIL oor_pulse i=%0d: got %b expected %0d", i, oerr_valid, r);
      end
      tick();
      n_chk++;
      if (oerr_valid !== '0) begin
        n_err++; $display("FAIL oor_clear i=%0d: got %b expected 0", i, oerr_valid);
      end
    end
    for (int j = 0; j < 20; j++) tick();
  endtask

  task automatic test_enable();
    int g;
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, rand_angs(1'b0), 1'b1, 1'b0);
      tick();
    end
    for (int j = 1; j <= 22; j++) begin
      drive(4'b0110, rand_angs(1'b0), 1'b0, 1'b0);
      n_chk++;
      if (oreq_ready !== '0) begin
        n_err++; $display("FAIL en_block j=%0d: got %b expected 0", j, oreq_ready);
      end
      tick();
      if (j == 18 || j == 19) begin
        n_chk++;
        if (obusy !== (j == 18)) begin
          n_err++; $display("FAIL en_busy j=%0d: got %b expected %b", j, obusy, (j == 18));
        end
      end
    end
    drive(4'b0110, rand_angs(1'b0), 1'b1, 1'b0);
    g = pick(ireq_valid, m_ptr, 1'b1);
    n_chk++;
    if (oreq_ready !== NREQ'(1 << g)) begin
      n_err++; $display("FAIL en_resume: got %b expected %0d", oreq_ready, g);
    end
    tick();
    drive('0, '0, 1'b1, 1'b0);
    for (int j = 0; j < 21; j++) tick();
  endtask

  task automatic test_random();
    int g;
    for (int k = 0; k < 300; k++) begin
      drive(NREQ'($urandom), rand_angs(1'b1), ($urandom_range(0, 7) != 0), 1'b0);
      g = pick(ireq_valid, m_ptr, ienable);
      n_chk++;
      if (oreq_ready !== ((g >= 0) ? NREQ'(1 << g) : '0)) begin
        n_err++; $display("FAIL rand_grant k=%0d: got %b expected %0d", k, oreq_ready, g);
      end
      tick();
    end
    drive('0, '0, 1'b1, 1'b0);
    for (int j = 0; j < 21; j++) tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, rand_angs(1'b0), 1'b1, 1'b0);
      tick();
    end
    drive('0, '0, 1'b1, 1'b1);
    tick();
    drive('0, '0, 1'b1, 1'b0);
    n_chk++;
    if (ores_valid !== '0 || oerr_valid !== '0 || ocordic_z !== '0 || ores_cos !== '0 ||
        ores_sin !== '0 || oinflight !== '0 || obusy !== 1'b0 || oreq_ready !== '0) begin
      n_err++; $display("FAIL midreset_state: got v=%b z=%0d c=%0d s=%0d n=%0d expected all zero", ores_valid, ocordic_z, ores_cos, ores_sin, oinflight);
    end
    for (int j = 0; j < 20; j++) begin
      tick();
      if (ores_valid != '0) pulses++;
    end
    n_chk++;
    if (pulses != 0) begin
      n_err++; $display("FAIL midreset_flush: got %0d pulses expected 0", pulses);
    end
  endtask

  initial begin
    @(negedge iclk);
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_out_of_range();
    test_enable();
    test_random();
    test_reset_mid();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cordic_sincos_arbiter.md
# cordic_sincos_arbiter

Shares one 18-stage pipelined CORDIC sin/cos unit among NREQ requesters, such as the SIFT orientation and descriptor units. The block performs round-robin arbitration and normalizes each granted angle into the CORDIC's [0, 360°) input range. It carries a requester tag alongside the pipeline and returns each cos/sin result to its originating requester as a one-cycle pulse. Angle format is degrees × 2^10 (full turn = 368640), signed 21-bit. Result format is Q.16 signed 21-bit, as produced by the CORDIC.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester index width, clog2(NREQ)
- LATENCY, 18, edges from ocordic_z change to matching icordic_x/icordic_y change
- FULL_TURN, 368640, 360° in angle units
- iclk  in  1  clock
- ireset  in  1  reset; synchronous and active-high
- ienable  in  1  issue enable; 0 blocks new grants, in-flight work drains
- ireq_valid  in  NREQ  per-requester request valid
- ireq_angle  in  21*NREQ  packed signed angles; requester r at [21r+20:21r]
- oreq_ready  out  NREQ  one-hot grant, combinational from ireq_valid, pointer and ienable
- ocordic_z  out  21  registered angle to the CORDIC iz port
- icordic_x  in  21  CORDIC cos output
- icordic_y  in  21  CORDIC sin output
- ores_valid  out  NREQ  one-hot result pulse, registered
- ores_cos  out  21  registered result cos
- ores_sin  out  21  registered result sin
- oerr_valid  out  NREQ  one-hot out-of-range pulse, registered
- oinflight  out  5  count of issued, unretired operations
- obusy  out  1  oinflight != 0

## Operation
- Arbitration: round-robin. The search starts at ptr+1 mod NREQ. At most one oreq_ready bit is set, and only if ienable=1. Transfer occurs when ireq_valid[r] & oreq_ready[r] at a rising edge. ptr <= r on transfer; ptr is unchanged otherwise. Reset value of ptr is NREQ-1, so requester 0 wins first.
- Normalization of accepted angle a (signed):
  - a < -FULL_TURN or a >= 2*FULL_TURN: out of range. The request is consumed, nothing is issued, and oerr_valid[r] pulses.
  - a < 0: z = a + FULL_TURN.
  - a >= FULL_TURN: z = a - FULL_TURN.
  - else: z = a.
- Normalization arithmetic uses 22-bit signed intermediates. The result always lies in [0, FULL_TURN-1].
- Issue: on a valid in-range transfer, ocordic_z <= z and tag {1, r} enters the tag shift register. With no issue, ocordic_z holds its last value and a {0, x} tag enters.
- Tag pipe: LATENCY stages, aligned so the tag at the last stage corresponds to the current icordic_x/icordic_y.
- Retire: if the last-stage tag is valid, then at the next edge ores_valid <= onehot(id), ores_cos <= icordic_x, ores_sin <= icordic_y. Otherwise ores_valid <= 0 and ores_cos/ores_sin hold.
- Consumers cannot back-pressure results; they must accept each pulse.
- oinflight: +1 on issue, -1 on retire, unchanged when both or neither occur. Issue rate is at most one per cycle, so the count never exceeds LATENCY+1.

## Timing
- Reset (ireset=1 at an edge): ptr=NREQ-1; ocordic_z=0; all tags invalid; ores_valid=0; ores_cos=0; ores_sin=0; oerr_valid=0; oinflight=0; obusy=0.
- Reset mid-operation discards all in-flight operations. CORDIC outputs from pre-reset issues are never reported, because their tags are cleared.
- Accept at edge T: ocordic_z is valid after T. The result arrives on icordic after edge T+LATENCY. ores_valid is high in the cycle after edge T+LATENCY+1, i.e. 19 edges after acceptance with defaults.
- oerr_valid is high in the cycle after edge T+1.
- Throughput is one operation per cycle across all requesters. Results return in issue order with no gaps beyond issue gaps.
- A same-cycle issue and retire are independent; the count is unchanged.
- ienable falling: grants stop in the same cycle, and obusy falls LATENCY+1 edges after the last issue.

## Test plan
- Reset, then r0 requests 30720 (30°) for one transfer: ocordic_z=30720 next cycle. ores_valid=0001 exactly 19 edges after acceptance, with ores_cos≈56756 and ores_sin≈32768 (±64) from a real CORDIC instance. oinflight goes 1 then 0.
- All four requesters hold valid for 8 cycles: grant order 0,1,2,3,0,1,2,3. ores_valid follows the same sequence back-to-back, and oinflight peaks at 8.
- Wrap cases, each checked at ocordic_z:
  - -92160 → 276480
  - 460800 → 92160
  - 368640 → 0
  - -368640 → 0
  - 368639 → 368639
- Out of range: 737280 and -368641 are each accepted with no issue. oerr_valid pulses for the correct requester one cycle later, oinflight is unchanged, and no ores_valid appears.
- ienable=0 while r1 and r2 are valid: oreq_ready=0. Five in-flight results still retire, and obusy drops after the last one. Re-enabling resumes from ptr+1.
- ireset pulsed for one cycle with 5 operations in flight: next cycle all outputs are 0. No ores_valid occurs in the following 20 cycles despite icordic activity.
